// File: rtl/banco_sched.sv
// banco_sched: two-requester round-robin write arbiter for a single-port bank,
// with a zero-fill sweep of the whole bank on request.
module banco_sched #(
    parameter int M = 32,
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [N-1:0] addr0,
    input  logic [M-1:0] data0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [N-1:0] addr1,
    input  logic [M-1:0] data1,
    output logic         gnt1,
    input  logic         clr_start,
    output logic         busy,
    output logic         done,
    output logic         wen,
    output logic [N-1:0] waddr,
    output logic [M-1:0] wdata
);

    typedef enum logic {NORMAL, CLEAR} state_t;

    // One past the last address; the extra counter bit stops the sweep cleanly.
    localparam logic [N:0] FILL_END = {1'b1, {N{1'b0}}};

    state_t       state, state_n;
    logic [N:0]   cnt, cnt_n;
    logic         ptr, ptr_n;
    logic         wen_n, done_n;
    logic [N-1:0] waddr_n;
    logic [M-1:0] wdata_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NORMAL;
            cnt   <= '0;
            ptr   <= 1'b0;
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            wen   <= wen_n;
            waddr <= waddr_n;
            wdata <= wdata_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        wen_n   = 1'b0;
        waddr_n = waddr;
        wdata_n = wdata;
        done_n  = 1'b0;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        unique case (state)
            NORMAL: begin
                if (clr_start) begin
                    state_n = CLEAR;
                    cnt_n   = {{N{1'b0}}, 1'b1};
                    wen_n   = 1'b1;
                    waddr_n = '0;
                    wdata_n = '0;
                end else begin
                    // ptr=1 means requester 1 wins the next tie
                    gnt0 = req0 && (!req1 || !ptr);
                    gnt1 = req1 && (!req0 || ptr);
                    if (gnt0) begin
                        wen_n   = 1'b1;
                        waddr_n = addr0;
                        wdata_n = data0;
                        ptr_n   = 1'b1;
                    end else if (gnt1) begin
                        wen_n   = 1'b1;
                        waddr_n = addr1;
                        wdata_n = data1;
                        ptr_n   = 1'b0;
                    end
                end
            end
            CLEAR: begin
                if (cnt == FILL_END) begin
                    state_n = NORMAL;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    wen_n   = 1'b1;
                    waddr_n = cnt[N-1:0];
                    wdata_n = '0;
                    cnt_n   = cnt + 1'b1;
                end
            end
            default: state_n = NORMAL;
        endcase
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign busy = (state == CLEAR);

endmodule
